io_input_debounce: RTL and testbench

//  Conditions raw DE2 board inputs (slide switches, push keys) into the clean 32-bit word

---
 rtl/io_input_debounce_pkg.sv | 10 +
 rtl/io_input_debounce_db_bit.sv | 49 ++++
 rtl/io_input_debounce.sv | 85 ++++++++
 tb/tb_io_input_debounce.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/io_input_debounce_pkg.sv
// Shared constants for the board input conditioner: bit positions of each field
// in the CPU-visible input word (same values the io decode and software headers use).
package io_input_debounce_pkg;

    localparam int unsigned IO_WORD_W   = 32;
    localparam int unsigned IO_SW_LSB   = 0;
    localparam int unsigned IO_KEY_LSB  = 10;
    localparam int unsigned IO_FLAG_LSB = 14;

endpackage

// File: rtl/io_input_debounce_db_bit.sv
// One conditioned input bit: two-flop synchroniser, hold-time counter and the
// accepted (stable) level. A new level is accepted only after DB_CYCLES clean cycles.
module io_input_debounce_db_bit #(
    parameter logic        RST_VAL   = 1'b0,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 19
) (
    input  logic clock,
    input  logic clrn,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            sync_q1 <= RST_VAL;
            sync_q2 <= RST_VAL;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // Any return to the accepted level restarts the count; the counter only
    // reaches CNT_LAST in the cycle that commits the new level.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else if (sync_q2 == stable_q) begin
            cnt_q    <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync_q2;
            cnt_q    <= '0;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/io_input_debounce.sv
// Conditions raw DE2 slide switches and active-low push keys into the registered
// 32-bit in_port0 word, with sticky key-press flags cleared by the CPU via flag_clr.
module io_input_debounce
    import io_input_debounce_pkg::*;
#(
    parameter int unsigned N_SW      = 10,
    parameter int unsigned N_KEY     = 4,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 19
) (
    input  logic                 clock,
    input  logic                 clrn,
    input  logic [N_SW-1:0]      sw_raw,
    input  logic [N_KEY-1:0]     key_raw,
    input  logic                 flag_clr,
    output logic [IO_WORD_W-1:0] in_port0,
    output logic [N_KEY-1:0]     key_event
);

    logic [N_SW-1:0]      sw_stable;
    logic [N_KEY-1:0]     key_stable_n;
    logic [N_KEY-1:0]     key_held;
    logic [N_KEY-1:0]     key_held_q;
    logic [N_KEY-1:0]     key_flag;
    logic [IO_WORD_W-1:0] word_next;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        io_input_debounce_db_bit #(
            .RST_VAL   (1'b0),
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clock (clock),
            .clrn  (clrn),
            .din   (sw_raw[i]),
            .dout  (sw_stable[i])
        );
    end

    // Keys are debounced in raw (active-low) polarity and inverted afterwards;
    // the inversion commutes with sync/debounce, so timing and reset state match.
    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        io_input_debounce_db_bit #(
            .RST_VAL   (1'b1),
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clock (clock),
            .clrn  (clrn),
            .din   (key_raw[k]),
            .dout  (key_stable_n[k])
        );
    end

    assign key_held = ~key_stable_n;

    // Set wins over clear, so a press coinciding with flag_clr is never lost.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            key_held_q <= '0;
            key_event  <= '0;
            key_flag   <= '0;
        end else begin
            key_held_q <= key_held;
            key_event  <= key_held & ~key_held_q;
            key_flag   <= key_event | (key_flag & ~{N_KEY{flag_clr}});
        end
    end

    always_comb begin
        word_next                          = '0;
        word_next[IO_SW_LSB   +: N_SW]     = sw_stable;
        word_next[IO_KEY_LSB  +: N_KEY]    = key_held;
        word_next[IO_FLAG_LSB +: N_KEY]    = key_flag;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            in_port0 <= '0;
        end else begin
            in_port0 <= word_next;
        end
    end

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce with a short debounce window; expected
// values are queued with a due cycle when stimulus is driven and checked on arrival.
module tb_io_input_debounce;

    logic        clock;
    logic        clrn;
    logic [9:0]  sw_raw;
    logic [3:0]  key_raw;
    logic        flag_clr;
    logic [31:0] in_port0;
    logic [3:0]  key_event;

    io_input_debounce #(
        .N_SW      (10),
        .N_KEY     (4),
        .DB_CYCLES (4),
        .CNT_W     (3)
    ) dut (
        .clock     (clock),
        .clrn      (clrn),
        .sw_raw    (sw_raw),
        .key_raw   (key_raw),
        .flag_clr  (flag_clr),
        .in_port0  (in_port0),
        .key_event (key_event)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int unsigned due;
        bit          is_evt;
        logic [31:0] mask;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic expect_at(input string tag, input int unsigned dly, input bit is_evt,
                             input logic [31:0] mask, input logic [31:0] val);
        exp_t e;
        e.tag    = tag;
        e.due    = cyc + dly;
        e.is_evt = is_evt;
        e.mask   = mask;
        e.val    = val;
        sb.push_back(e);
    endtask

    task automatic scan();
        int unsigned i;
        logic [31:0] obs;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                obs = sb[i].is_evt ? {28'h0, key_event} : in_port0;
                obs = obs & sb[i].mask;
                n_checks++;
                assert (obs === sb[i].val) else begin
                    n_fail++;
                    $error("FAIL %s: observed %h expected %h (cycle %0d)",
                           sb[i].tag, obs, sb[i].val, cyc);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(negedge clock);
            cyc++;
            scan();
        end
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        sw_raw   = '0;
        key_raw  = '1;
        flag_clr = 1'b0;
        clrn     = 1'b1;

        // 1: reset with all switches up and all keys pressed
        #2;
        clrn    = 1'b0;
        sw_raw  = 10'h3FF;
        key_raw = 4'h0;
        tick(2);
        expect_at("rst_word", 0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        expect_at("rst_evt",  0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        scan();
        clrn = 1'b1;
        expect_at("rst_sw_early", 6, 1'b0, 32'h3FF,   32'h0);
        expect_at("rst_sw",       7, 1'b0, 32'h3FF,   32'h3FF);
        expect_at("rst_keys",     7, 1'b0, 32'h3C00,  32'h3C00);
        expect_at("rst_evt_all",  7, 1'b1, 32'hF,     32'hF);
        expect_at("rst_evt_gone", 8, 1'b1, 32'hF,     32'h0);
        expect_at("rst_flags",    9, 1'b0, 32'h3C000, 32'h3C000);
        tick(9);
        sw_raw  = '0;
        key_raw = '1;
        expect_at("release_all",    8, 1'b0, 32'hFFFF_FFFF, 32'h3C000);
        expect_at("release_no_evt", 8, 1'b1, 32'hF,         32'h0);
        tick(8);
        pulse_clr();
        expect_at("clr_all", 1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        tick(1);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        sw_raw[3] = 1'b1;
        for (int unsigned i = 1; i <= 12; i++)
            expect_at("glitch_hold", i, 1'b0, 32'h8, 32'h0);
        tick(3);
        sw_raw[3] = 1'b0;
        tick(9);
        sw_raw[3] = 1'b1;
        expect_at("pulse4_early", 6, 1'b0, 32'h8,         32'h0);
        expect_at("pulse4_set",   7, 1'b0, 32'hFFFF_FFFF, 32'h8);
        tick(4);
        sw_raw[3] = 1'b0;
        expect_at("pulse4_still", 6, 1'b0, 32'h8, 32'h8);
        expect_at("pulse4_clear", 7, 1'b0, 32'h8, 32'h0);
        tick(8);

        // 3: key 2 press held 20 cycles, then released
        key_raw[2] = 1'b0;
        expect_at("press_evt_early", 6, 1'b1, 32'hF,         32'h0);
        expect_at("press_evt",       7, 1'b1, 32'hF,         32'h4);
        expect_at("press_key",       7, 1'b0, 32'hFFFF_FFFF, 32'h1000);
        expect_at("press_evt_once",  8, 1'b1, 32'hF,         32'h0);
        expect_at("press_flag",      9, 1'b0, 32'hFFFF_FFFF, 32'h11000);
        tick(20);
        key_raw[2] = 1'b1;
        expect_at("release_key",  7, 1'b0, 32'hFFFF_FFFF, 32'h10000);
        expect_at("release_evt",  8, 1'b1, 32'hF,         32'h0);
        tick(10);
        pulse_clr();
        expect_at("clr_after_release", 1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        tick(1);

        // 4: clear while key 2 is still held
        key_raw[2] = 1'b0;
        expect_at("held_flag", 12, 1'b0, 32'hFFFF_FFFF, 32'h11000);
        tick(12);
        pulse_clr();
        expect_at("clr_held", 1, 1'b0, 32'hFFFF_FFFF, 32'h1000);
        for (int unsigned i = 1; i <= 6; i++)
            expect_at("clr_no_evt", i, 1'b1, 32'hF, 32'h0);
        expect_at("clr_no_reset", 6, 1'b0, 32'hFFFF_FFFF, 32'h1000);
        tick(6);
        key_raw[2] = 1'b1;
        expect_at("held_release", 8, 1'b0, 32'hFFFF_FFFF, 32'h0);
        tick(8);

        // 5: flag_clr in the same cycle as key_event[0]
        key_raw[0] = 1'b0;
        expect_at("simul_evt", 7, 1'b1, 32'hF, 32'h1);
        tick(7);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        expect_at("simul_flag", 1, 1'b0, 32'hFFFF_FFFF, 32'h4400);
        tick(1);
        key_raw[0] = 1'b1;
        tick(8);
        pulse_clr();
        expect_at("simul_cleanup", 1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        tick(1);

        // 6: reset in the middle of a switch count
        sw_raw[1] = 1'b1;
        expect_at("pre_rst_sw1", 8, 1'b0, 32'hFFFF_FFFF, 32'h2);
        tick(8);
        sw_raw[5] = 1'b1;
        tick(4);
        clrn = 1'b0;
        #1;
        expect_at("mid_rst_word", 0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        expect_at("mid_rst_evt",  0, 1'b1, 32'hF,         32'h0);
        scan();
        tick(2);
        clrn = 1'b1;
        expect_at("mid_rst_early", 6, 1'b0, 32'hFFFF_FFFF, 32'h0);
        expect_at("mid_rst_new",   7, 1'b0, 32'hFFFF_FFFF, 32'h22);
        tick(8);

        tick(2);
        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
